// File: rtl/p_simd_pkg.sv
// rtl/p_simd_pkg.sv - shared widths and writeback entry type for the packed-SIMD datapath
package p_simd_pkg;
  localparam int REG_WIDTH  = 64;
  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 32;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [REG_WIDTH-1:0]  data;
  } wb_entry_t;

  function automatic logic [NUM_REGS-1:0] rd_decode(input logic [REG_ADDR_W-1:0] rd);
    return NUM_REGS'(1) << rd;
  endfunction
endpackage

// File: rtl/p_wb_fifo.sv
// rtl/p_wb_fifo.sv - per-source writeback result FIFO with per-entry visibility for hazard tracking
module p_wb_fifo
  import p_simd_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             push,
  input  wb_entry_t                        push_entry,
  input  logic                             pop,
  output logic                             full,
  output logic                             empty,
  output wb_entry_t                        head,
  output logic [DEPTH-1:0]                 entry_valid,
  output logic [DEPTH-1:0][REG_ADDR_W-1:0] entry_rd
);
  localparam int AW = $clog2(DEPTH);

  // Pointers carry one wrap bit above the address so full and empty are distinguishable.
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  wb_entry_t   mem [DEPTH];
  logic        do_push;
  logic        do_pop;

  assign full    = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign empty   = (wr_ptr == rd_ptr);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr[AW-1:0]];

  always_comb begin
    for (int i = 0; i < DEPTH; i++) entry_rd[i] = mem[i].rd;
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_entry;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      entry_valid <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      // Push and pop never target the same slot: that needs full or empty, which blocks one of them.
      for (int i = 0; i < DEPTH; i++) begin
        if (do_push && wr_ptr[AW-1:0] == AW'(i))     entry_valid[i] <= 1'b1;
        else if (do_pop && rd_ptr[AW-1:0] == AW'(i)) entry_valid[i] <= 1'b0;
      end
    end
  end
endmodule

// File: rtl/p_wb_arbiter.sv
// rtl/p_wb_arbiter.sv - round-robin writeback serializer of FMA and ALU results onto the register-file write port
module p_wb_arbiter
  import p_simd_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  s0_valid,
  output logic                  s0_ready,
  input  logic [REG_ADDR_W-1:0] s0_rd,
  input  logic [REG_WIDTH-1:0]  s0_data,
  input  logic                  s1_valid,
  output logic                  s1_ready,
  input  logic [REG_ADDR_W-1:0] s1_rd,
  input  logic [REG_WIDTH-1:0]  s1_data,
  output logic [REG_ADDR_W-1:0] rd_address,
  output logic                  wr_enable,
  output logic [REG_WIDTH-1:0]  wr_data,
  output logic [NUM_REGS-1:0]   pending_mask
);
  logic      ready_en;
  logic      full0, empty0, full1, empty1;
  logic      gnt0, gnt1;
  logic      rr_ptr;
  wb_entry_t head0, head1;
  logic [FIFO_DEPTH-1:0]                 vld0, vld1;
  logic [FIFO_DEPTH-1:0][REG_ADDR_W-1:0] rd0, rd1;

  // ready_en keeps both sources stalled through reset and the first cycle after release.
  assign s0_ready = ready_en && !full0;
  assign s1_ready = ready_en && !full1;

  p_wb_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo0 (
    .clk(clk), .rst_n(rst_n),
    .push(s0_valid && s0_ready), .push_entry('{rd: s0_rd, data: s0_data}),
    .pop(gnt0), .full(full0), .empty(empty0), .head(head0),
    .entry_valid(vld0), .entry_rd(rd0)
  );

  p_wb_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo1 (
    .clk(clk), .rst_n(rst_n),
    .push(s1_valid && s1_ready), .push_entry('{rd: s1_rd, data: s1_data}),
    .pop(gnt1), .full(full1), .empty(empty1), .head(head1),
    .entry_valid(vld1), .entry_rd(rd1)
  );

  // rr_ptr=0 favours src0 when both heads are waiting.
  assign gnt0 = !empty0 && (empty1 || !rr_ptr);
  assign gnt1 = !empty1 && (empty0 || rr_ptr);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ready_en   <= 1'b0;
      rr_ptr     <= 1'b0;
      wr_enable  <= 1'b0;
      rd_address <= '0;
      wr_data    <= '0;
    end else begin
      ready_en  <= 1'b1;
      wr_enable <= gnt0 || gnt1;
      if (gnt0) begin
        rd_address <= head0.rd;
        wr_data    <= head0.data;
        rr_ptr     <= 1'b1;
      end else if (gnt1) begin
        rd_address <= head1.rd;
        wr_data    <= head1.data;
        rr_ptr     <= 1'b0;
      end
    end
  end

  always_comb begin
    pending_mask = '0;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      if (vld0[i]) pending_mask = pending_mask | rd_decode(rd0[i]);
      if (vld1[i]) pending_mask = pending_mask | rd_decode(rd1[i]);
    end
    if (wr_enable) pending_mask = pending_mask | rd_decode(rd_address);
  end
endmodule

// File: tb/tb_p_wb_arbiter.sv
// tb/tb_p_wb_arbiter.sv - scoreboard bench for the writeback arbiter
module tb_p_wb_arbiter;
  import p_simd_pkg::*;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        s0_valid, s0_ready, s1_valid, s1_ready;
  logic [4:0]  s0_rd, s1_rd, rd_address;
  logic [63:0] s0_data, s1_data, wr_data;
  logic        wr_enable;
  logic [31:0] pending_mask;

  int n_checks = 0;
  int n_fail   = 0;

  logic [68:0] q0 [$];
  logic [68:0] q1 [$];
  logic [68:0] exp_q [$];
  logic [31:0] mask_q [$];
  logic [63:0] rf [32];

  always #5 clk = ~clk;

  p_wb_arbiter #(.FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .s0_valid(s0_valid), .s0_ready(s0_ready), .s0_rd(s0_rd), .s0_data(s0_data),
    .s1_valid(s1_valid), .s1_ready(s1_ready), .s1_rd(s1_rd), .s1_data(s1_data),
    .rd_address(rd_address), .wr_enable(wr_enable), .wr_data(wr_data),
    .pending_mask(pending_mask)
  );

  // Behavioural stand-in for p_reg_file's write port.
  always @(posedge clk) if (wr_enable) rf[rd_address] <= wr_data;

  function automatic logic [63:0] mk_data(input logic src, input int seq, input logic [4:0] rd);
    return {src, 31'(seq), 27'h2A55A5A, rd};
  endfunction

  task automatic idle_inputs();
    s0_valid = 1'b0; s0_rd = '0; s0_data = '0;
    s1_valid = 1'b0; s1_rd = '0; s1_data = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    idle_inputs();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if (wr_enable !== 1'b0 || pending_mask !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: wr_enable=%b pending_mask=%h, required 0 and 00000000", wr_enable, pending_mask);
    end
    n_checks++;
    if (s0_ready !== 1'b0 || s1_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ready_low: s0_ready=%b s1_ready=%b, required 0 0", s0_ready, s1_ready);
    end
    n_checks++;
    if (rd_address !== 5'd0 || wr_data !== 64'h0) begin
      n_fail++;
      $display("FAIL reset_outregs: rd_address=%0d wr_data=%h, required 0 0", rd_address, wr_data);
    end
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (s0_ready !== 1'b1 || s1_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_ready_release: s0_ready=%b s1_ready=%b, required 1 1", s0_ready, s1_ready);
    end
  endtask

  task automatic test_single_write();
    logic [68:0] e;
    s1_valid = 1'b1; s1_rd = 5'd3; s1_data = 64'hA5A5_A5A5_A5A5_A5A5;
    q1.push_back({5'd3, 64'hA5A5_A5A5_A5A5_A5A5});
    @(negedge clk);
    idle_inputs();
    n_checks++;
    if (pending_mask !== 32'h8 || wr_enable !== 1'b0) begin
      n_fail++;
      $display("FAIL single_accept: pending_mask=%h wr_enable=%b, required 00000008 0", pending_mask, wr_enable);
    end
    @(negedge clk);
    n_checks++;
    if (wr_enable !== 1'b1 || q1.size() == 0) begin
      n_fail++;
      $display("FAIL single_wr_enable: wr_enable=%b, required 1", wr_enable);
    end else begin
      e = q1.pop_front();
      n_checks++;
      if ({rd_address, wr_data} !== e || pending_mask !== 32'h8) begin
        n_fail++;
        $display("FAIL single_write_data: rd=%0d data=%h mask=%h, required rd=%0d data=%h mask=00000008",
                 rd_address, wr_data, pending_mask, e[68:64], e[63:0]);
      end
    end
    @(negedge clk);
    n_checks++;
    if (wr_enable !== 1'b0 || pending_mask !== 32'h0 || rf[3] !== 64'hA5A5_A5A5_A5A5_A5A5) begin
      n_fail++;
      $display("FAIL single_commit: wr_enable=%b mask=%h rf[3]=%h, required 0 00000000 a5a5a5a5a5a5a5a5",
               wr_enable, pending_mask, rf[3]);
    end
  endtask

  task automatic test_contention();
    int idx = 0, writes = 0, first_cyc = -1, last_cyc = -1;
    bit done = 0;
    logic [68:0] e;
    do_reset();
    exp_q.delete();
    for (int cyc = 0; cyc < 40 && !done; cyc++) begin
      if (cyc > 0) @(negedge clk);
      if (wr_enable) begin
        if (first_cyc < 0) first_cyc = cyc;
        last_cyc = cyc;
        writes++;
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL contention_extra: unexpected write rd=%0d", rd_address);
        end else begin
          e = exp_q.pop_front();
          if ({rd_address, wr_data} !== e) begin
            n_fail++;
            $display("FAIL contention_order: rd=%0d data=%h, required rd=%0d data=%h",
                     rd_address, wr_data, e[68:64], e[63:0]);
          end
        end
      end
      if (idx < 4) begin
        n_checks++;
        if (s0_ready !== 1'b1 || s1_ready !== 1'b1) begin
          n_fail++;
          $display("FAIL contention_ready: s0_ready=%b s1_ready=%b, required 1 1", s0_ready, s1_ready);
        end
        s0_valid = 1'b1; s0_rd = 5'(1 + idx);  s0_data = mk_data(1'b0, idx, 5'(1 + idx));
        s1_valid = 1'b1; s1_rd = 5'(11 + idx); s1_data = mk_data(1'b1, idx, 5'(11 + idx));
        exp_q.push_back({s0_rd, s0_data});
        exp_q.push_back({s1_rd, s1_data});
        idx++;
      end else begin
        idle_inputs();
        if (exp_q.size() == 0 && !wr_enable && writes > 0) done = 1;
      end
    end
    n_checks++;
    if (!done || writes != 8 || last_cyc - first_cyc != 7) begin
      n_fail++;
      $display("FAIL contention_b2b: writes=%0d span=%0d done=%0d, required 8 writes over 8 consecutive cycles",
               writes, last_cyc - first_cyc + 1, done);
    end
  endtask

  task automatic test_backpressure();
    int idx0 = 0, idx1 = 0, writes = 0;
    bit saw_low = 0, done = 0;
    logic [68:0] e;
    do_reset();
    q0.delete(); q1.delete();
    for (int cyc = 0; cyc < 200 && !done; cyc++) begin
      if (cyc > 0) @(negedge clk);
      if (wr_enable) begin
        writes++;
        n_checks++;
        if (wr_data[63] == 1'b0 ? q0.size() == 0 : q1.size() == 0) begin
          n_fail++;
          $display("FAIL bp_dup: write rd=%0d data=%h with nothing outstanding", rd_address, wr_data);
        end else begin
          e = wr_data[63] ? q1.pop_front() : q0.pop_front();
          if ({rd_address, wr_data} !== e) begin
            n_fail++;
            $display("FAIL bp_order: rd=%0d data=%h, required rd=%0d data=%h",
                     rd_address, wr_data, e[68:64], e[63:0]);
          end
        end
      end
      if (!s0_ready) saw_low = 1;
      if (idx0 < 12) begin
        s0_valid = 1'b1; s0_rd = 5'(5 + idx0); s0_data = mk_data(1'b0, idx0, 5'(5 + idx0));
        if (s0_ready) begin q0.push_back({s0_rd, s0_data}); idx0++; end
      end else s0_valid = 1'b0;
      if (idx1 < 12) begin
        s1_valid = 1'b1; s1_rd = 5'(18 + idx1); s1_data = mk_data(1'b1, idx1, 5'(18 + idx1));
        if (s1_ready) begin q1.push_back({s1_rd, s1_data}); idx1++; end
      end else s1_valid = 1'b0;
      if (idx0 == 12 && idx1 == 12 && q0.size() == 0 && q1.size() == 0) done = 1;
    end
    idle_inputs();
    n_checks++;
    if (!saw_low) begin
      n_fail++;
      $display("FAIL bp_ready_drop: s0_ready never low, required a drop when FIFO fills");
    end
    n_checks++;
    if (!done || writes != 24) begin
      n_fail++;
      $display("FAIL bp_count: writes=%0d done=%0d left0=%0d left1=%0d, required 24 1 0 0",
               writes, done, q0.size(), q1.size());
    end
  endtask

  task automatic test_hazard_mask();
    logic [31:0] m;
    do_reset();
    s0_valid = 1'b1; s0_rd = 5'd7; s0_data = 64'h7;
    s1_valid = 1'b1; s1_rd = 5'd9; s1_data = 64'h9;
    mask_q.push_back(32'h0000_0280);
    mask_q.push_back(32'h0000_0280);
    mask_q.push_back(32'h0000_0200);
    mask_q.push_back(32'h0000_0000);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      idle_inputs();
      m = mask_q.pop_front();
      n_checks++;
      if (pending_mask !== m) begin
        n_fail++;
        $display("FAIL hazard_mask_%0d: pending_mask=%h, required %h", c, pending_mask, m);
      end
    end
  endtask

  task automatic test_reset_mid_op();
    int pulses = 0, bad_mask = 0;
    do_reset();
    for (int c = 0; c < 3; c++) begin
      s0_valid = 1'b1; s0_rd = 5'(20 + c); s0_data = mk_data(1'b0, c, 5'(20 + c));
      s1_valid = 1'b1; s1_rd = 5'(25 + c); s1_data = mk_data(1'b1, c, 5'(25 + c));
      @(negedge clk);
    end
    idle_inputs();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    n_checks++;
    if (wr_enable !== 1'b0 || pending_mask !== 32'h0 || s0_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL midreset_clear: wr_enable=%b mask=%h s0_ready=%b, required 0 00000000 0",
               wr_enable, pending_mask, s0_ready);
    end
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (wr_enable) pulses++;
      if (pending_mask != 32'h0) bad_mask++;
    end
    n_checks++;
    if (pulses != 0 || bad_mask != 0) begin
      n_fail++;
      $display("FAIL midreset_drop: wr_enable pulses=%0d nonzero masks=%0d, required 0 0", pulses, bad_mask);
    end
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_single_write();
    test_contention();
    test_backpressure();
    test_hazard_mask();
    test_reset_mid_op();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
